// File: rtl/vga_timing_sequencer.sv
// vga_timing_sequencer: raster sequencer for the 800x600@72 display path.
//   Tracks (h,v) with horizontal/vertical phase FSMs and emits sync, display
//   enable, raster position and a render window with window-local coordinates.
// Latency: every output is registered and describes the position the counters
//   held on the emitting edge, so outputs lag the counters by one edge.
// Stall: on edges with run=0 the counters and position outputs hold, while the
//   qualifiers (de, win_active, line_start, frame_start) drop to 0, so no
//   pixel is ever emitted twice or skipped.
// Ports:
//   clk, reset (async, active-high), run (advance enable)
//   hsync, vsync, de             - sync and visible-area enable
//   x, y                         - raster position of the emitted pixel
//   win_active, win_x, win_y     - render window flag and local coordinates
//   line_start, frame_start      - one-cycle strobes at x=0 / (0,0)
//   frame_cnt                    - completed frames, modulo 2^16
module vga_timing_sequencer #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 56,
  parameter int   H_SYNC   = 120,
  parameter int   H_BP     = 64,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 37,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1,
  parameter int   WIN_X0   = 144,
  parameter int   WIN_Y0   = 172,
  parameter int   WIN_W    = 512,
  parameter int   WIN_H    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        win_active,
  output logic [8:0]  win_x,
  output logic [7:0]  win_y,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the phase changes as the counter leaves it.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_FP_END   = 11'(H_ACTIVE + H_FP - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  localparam logic [10:0] WX_LO = 11'(WIN_X0);
  localparam logic [10:0] WX_HI = 11'(WIN_X0 + WIN_W);
  localparam logic [9:0]  WY_LO = 10'(WIN_Y0);
  localparam logic [9:0]  WY_HI = 10'(WIN_Y0 + WIN_H);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_t;

  // Raster state
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  phase_t      h_ph_q, h_ph_d;
  phase_t      v_ph_q, v_ph_d;
  logic [15:0] wrap_cnt_q, wrap_cnt_d;

  // Output registers
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        win_active_q, win_active_d;
  logic [8:0]  win_x_q, win_x_d;
  logic [7:0]  win_y_q, win_y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic h_wrap;
  logic frame_wrap;
  logic in_win;

  always_comb begin
    h_d        = h_q;
    v_d        = v_q;
    h_ph_d     = h_ph_q;
    v_ph_d     = v_ph_q;
    wrap_cnt_d = wrap_cnt_q;

    h_wrap     = (h_q == H_LAST);
    frame_wrap = h_wrap && (v_q == V_LAST);

    if (run) begin
      if (h_wrap) begin
        h_d    = '0;
        h_ph_d = PH_ACTIVE;
      end else begin
        h_d = h_q + 11'd1;
        if (h_q == H_ACT_END)       h_ph_d = PH_FP;
        else if (h_q == H_FP_END)   h_ph_d = PH_SYNC;
        else if (h_q == H_SYNC_END) h_ph_d = PH_BP;
      end

      if (h_wrap) begin
        if (v_q == V_LAST) begin
          v_d    = '0;
          v_ph_d = PH_ACTIVE;
        end else begin
          v_d = v_q + 10'd1;
          if (v_q == V_ACT_END)       v_ph_d = PH_FP;
          else if (v_q == V_FP_END)   v_ph_d = PH_SYNC;
          else if (v_q == V_SYNC_END) v_ph_d = PH_BP;
        end
      end

      if (frame_wrap) wrap_cnt_d = wrap_cnt_q + 16'd1;
    end
  end

  assign in_win = (h_q >= WX_LO) && (h_q < WX_HI) && (v_q >= WY_LO) && (v_q < WY_HI);

  always_comb begin
    // Position-type outputs hold across a stall; qualifiers drop to 0.
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    x_d           = x_q;
    y_d           = y_q;
    win_x_d       = win_x_q;
    win_y_d       = win_y_q;
    frame_cnt_d   = frame_cnt_q;
    de_d          = 1'b0;
    win_active_d  = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (run) begin
      hsync_d       = (h_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = (v_ph_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      de_d          = (h_ph_q == PH_ACTIVE) && (v_ph_q == PH_ACTIVE);
      x_d           = h_q;
      y_d           = v_q;
      win_active_d  = in_win;
      win_x_d       = in_win ? 9'(h_q - WX_LO) : '0;
      win_y_d       = in_win ? 8'(v_q - WY_LO) : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = (h_q == '0) && (v_q == '0);
      // The internal wrap count bumps on the edge that emits the last pixel;
      // loading it here makes frame_cnt step together with the emitted (0,0),
      // keeping it aligned with every other output.
      frame_cnt_d   = wrap_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      h_ph_q        <= PH_ACTIVE;
      v_ph_q        <= PH_ACTIVE;
      wrap_cnt_q    <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      win_active_q  <= 1'b0;
      win_x_q       <= '0;
      win_y_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      h_ph_q        <= h_ph_d;
      v_ph_q        <= v_ph_d;
      wrap_cnt_q    <= wrap_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      win_active_q  <= win_active_d;
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign win_active  = win_active_q;
  assign win_x       = win_x_q;
  assign win_y       = win_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Bench for vga_timing_sequencer: a full-size instance for line-level timing,
// reset and stall behaviour, and a small-raster instance so whole frames,
// vsync and the window fit in a short run.
module tb_vga_timing_sequencer;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [9:0]  y;
    logic        wa;
    logic [8:0]  wx;
    logic [7:0]  wy;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  typedef struct packed {
    logic r;
    obs_t o;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic run_b = 1'b0;
  logic run_s = 1'b0;

  logic        b_hs, b_vs, b_de, b_wa, b_ls, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic [8:0]  b_wx;
  logic [7:0]  b_wy;
  logic [15:0] b_fc;
  logic        s_hs, s_vs, s_de, s_wa, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;
  logic [8:0]  s_wx;
  logic [7:0]  s_wy;
  logic [15:0] s_fc;

  obs_t b_now, s_now;
  assign b_now = {b_hs, b_vs, b_de, b_x, b_y, b_wa, b_wx, b_wy, b_ls, b_fs, b_fc};
  assign s_now = {s_hs, s_vs, s_de, s_x, s_y, s_wa, s_wx, s_wy, s_ls, s_fs, s_fc};

  always #5 clk = ~clk;

  vga_timing_sequencer dut_b (
    .clk(clk), .reset(reset), .run(run_b),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .x(b_x), .y(b_y),
    .win_active(b_wa), .win_x(b_wx), .win_y(b_wy),
    .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  vga_timing_sequencer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1),
    .WIN_X0(2), .WIN_Y0(1), .WIN_W(4), .WIN_H(3)
  ) dut_s (
    .clk(clk), .reset(reset), .run(run_s),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .win_active(s_wa), .win_x(s_wx), .win_y(s_wy),
    .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
  );

  int checks = 0;
  int failures = 0;

  ent_t qb[$];
  ent_t qs[$];
  int   pb = 0;
  int   ps = 0;
  obs_t last_b = '0;
  obs_t last_s = '0;

  // Measurements taken from DUT outputs on run cycles
  int b_ls_seen, b_since, lsp_min, lsp_max;
  int b_de_cnt, b_hs_cnt, b_hs_xmin, b_hs_xmax;
  int s_fs_seen, s_since, fsp_min, fsp_max;
  int s_wcnt, s_wmin, s_wmax;
  int s_vs_ymin, s_vs_ymax;
  int s_wa_xmin, s_wa_xmax, s_wa_ymin, s_wa_ymax, s_wx_max, s_wy_max;

  task automatic clear_stats();
    b_ls_seen = 0; b_since = 0; lsp_min = 99999; lsp_max = -1;
    b_de_cnt = 0; b_hs_cnt = 0; b_hs_xmin = 99999; b_hs_xmax = -1;
    s_fs_seen = 0; s_since = 0; fsp_min = 99999; fsp_max = -1;
    s_wcnt = 0; s_wmin = 99999; s_wmax = -1;
    s_vs_ymin = 99999; s_vs_ymax = -1;
    s_wa_xmin = 99999; s_wa_xmax = -1; s_wa_ymin = 99999; s_wa_ymax = -1;
    s_wx_max = -1; s_wy_max = -1;
  endtask

  // Closed-form expectation for raster index p of a given timing set.
  function automatic obs_t model(int p, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb,
                                 int wx0, int wy0, int ww, int wh);
    int   ht = ha + hf + hsw + hb;
    int   vt = va + vf + vsw + vb;
    int   h  = p % ht;
    int   v  = (p / ht) % vt;
    obs_t o;
    o.hs = (h >= ha + hf) && (h < ha + hf + hsw);
    o.vs = (v >= va + vf) && (v < va + vf + vsw);
    o.de = (h < ha) && (v < va);
    o.x  = 11'(h);
    o.y  = 10'(v);
    o.wa = (h >= wx0) && (h < wx0 + ww) && (v >= wy0) && (v < wy0 + wh);
    o.wx = o.wa ? 9'(h - wx0) : 9'd0;
    o.wy = o.wa ? 8'(v - wy0) : 8'd0;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.fc = 16'(p / (ht * vt));
    return o;
  endfunction

  function automatic obs_t held(obs_t o);
    obs_t r = o;
    r.de = 1'b0;
    r.wa = 1'b0;
    r.ls = 1'b0;
    r.fs = 1'b0;
    return r;
  endfunction

  task automatic chk_obs(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got x=%0d y=%0d {%h} expected x=%0d y=%0d {%h}",
               nm, act.x, act.y, act, exp.x, exp.y, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // One cycle of stimulus: drive run for the next edge and queue what each
  // instance must show after it.
  task automatic cyc(input logic rb, input logic rs);
    ent_t e;
    @(negedge clk);
    run_b = rb;
    run_s = rs;
    if (rb) begin
      last_b = model(pb, 800, 56, 120, 64, 600, 37, 6, 23, 144, 172, 512, 256);
      pb++;
    end else begin
      last_b = held(last_b);
    end
    e.r = rb; e.o = last_b;
    qb.push_back(e);
    if (rs) begin
      last_s = model(ps, 8, 2, 3, 2, 6, 1, 2, 1, 2, 1, 4, 3);
      ps++;
    end else begin
      last_s = held(last_s);
    end
    e.r = rs; e.o = last_s;
    qs.push_back(e);
  endtask

  // Monitor: pops and compares a few time units after each edge.
  ent_t eb, es;
  always begin
    @(posedge clk);
    #3;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk_obs("big_pixel", b_now, eb.o);
      if (eb.r) begin
        if (b_ls) begin
          if (b_ls_seen != 0) begin
            if (b_since < lsp_min) lsp_min = b_since;
            if (b_since > lsp_max) lsp_max = b_since;
          end
          b_ls_seen = 1;
          b_since = 1;
        end else begin
          b_since++;
        end
        if (b_y == 10'd1) begin
          if (b_de) b_de_cnt++;
          if (b_hs) begin
            b_hs_cnt++;
            if (int'(b_x) < b_hs_xmin) b_hs_xmin = int'(b_x);
            if (int'(b_x) > b_hs_xmax) b_hs_xmax = int'(b_x);
          end
        end
      end
    end
    if (qs.size() > 0) begin
      es = qs.pop_front();
      chk_obs("small_pixel", s_now, es.o);
      if (es.r) begin
        if (s_fs) begin
          if (s_fs_seen != 0) begin
            if (s_since < fsp_min) fsp_min = s_since;
            if (s_since > fsp_max) fsp_max = s_since;
            if (s_wcnt < s_wmin) s_wmin = s_wcnt;
            if (s_wcnt > s_wmax) s_wmax = s_wcnt;
          end
          s_fs_seen = 1;
          s_since = 1;
          s_wcnt = 0;
        end else begin
          s_since++;
        end
        if (s_vs) begin
          if (int'(s_y) < s_vs_ymin) s_vs_ymin = int'(s_y);
          if (int'(s_y) > s_vs_ymax) s_vs_ymax = int'(s_y);
        end
        if (s_wa) begin
          s_wcnt++;
          if (int'(s_x) < s_wa_xmin) s_wa_xmin = int'(s_x);
          if (int'(s_x) > s_wa_xmax) s_wa_xmax = int'(s_x);
          if (int'(s_y) < s_wa_ymin) s_wa_ymin = int'(s_y);
          if (int'(s_y) > s_wa_ymax) s_wa_ymax = int'(s_y);
          if (int'(s_wx) > s_wx_max) s_wx_max = int'(s_wx);
          if (int'(s_wy) > s_wy_max) s_wy_max = int'(s_wy);
        end
      end
    end
  end

  initial begin
    int stall_n;
    logic rb, rs;
    clear_stats();
    #1;
    chk_obs("reset_state_big", b_now, '0);
    chk_obs("reset_state_small", s_now, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Run the big raster to emitted position (300,10): index 10*1040+300.
    for (int i = 0; i < 10701; i++) cyc(1'b1, 1'b1);
    @(posedge clk);
    #4;
    chk_int("pre_reset_x", int'(b_x), 300);
    chk_int("pre_reset_y", int'(b_y), 10);

    // Asynchronous reset mid-line: outputs must clear without an edge.
    run_b = 1'b0;
    run_s = 1'b0;
    reset = 1'b1;
    #1;
    chk_obs("async_reset_big", b_now, '0);
    chk_obs("async_reset_small", s_now, '0);
    pb = 0; ps = 0;
    last_b = '0; last_s = '0;
    clear_stats();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Several big lines with a 5-cycle stall after x=400 on line 2; the small
    // raster runs with a periodic 2-in-11 stall pattern.
    stall_n = 0;
    for (int i = 0; i < 4180; i++) begin
      rb = 1'b1;
      if (pb == 2 * 1040 + 401 && stall_n < 5) begin
        rb = 1'b0;
        stall_n++;
      end
      rs = ((i % 11) >= 2);
      cyc(rb, rs);
    end
    @(posedge clk);
    #4;
    run_b = 1'b0;
    run_s = 1'b0;

    chk_int("queue_big_drained", qb.size(), 0);
    chk_int("queue_small_drained", qs.size(), 0);
    chk_int("line_period_min", lsp_min, 1040);
    chk_int("line_period_max", lsp_max, 1040);
    chk_int("de_cycles_line", b_de_cnt, 800);
    chk_int("hsync_cycles_line", b_hs_cnt, 120);
    chk_int("hsync_first_x", b_hs_xmin, 856);
    chk_int("hsync_last_x", b_hs_xmax, 975);
    chk_int("frame_period_min", fsp_min, 150);
    chk_int("frame_period_max", fsp_max, 150);
    chk_int("win_cycles_min", s_wmin, 12);
    chk_int("win_cycles_max", s_wmax, 12);
    chk_int("vsync_first_line", s_vs_ymin, 7);
    chk_int("vsync_last_line", s_vs_ymax, 8);
    chk_int("win_first_x", s_wa_xmin, 2);
    chk_int("win_last_x", s_wa_xmax, 5);
    chk_int("win_first_y", s_wa_ymin, 1);
    chk_int("win_last_y", s_wa_ymax, 3);
    chk_int("win_x_max", s_wx_max, 3);
    chk_int("win_y_max", s_wy_max, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
